trees_burst_driver: RTL

//  Host-side driver for the tree-ensemble ping-pong accelerator. Accepts a burst config, streams

---
 rtl/trees_burst_driver_pkg.sv | 26 ++
 rtl/trees_burst_driver_if.sv | 41 ++++
 rtl/trees_burst_driver.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/trees_burst_driver_pkg.sv
// Shared types and width helpers for the tree-ensemble burst driver and its accelerator.
package trees_burst_driver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StRun,
    StDrain,
    StFin
  } drv_state_e;

  function automatic int unsigned burst_len_width(int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  function automatic int unsigned feat_addr_width(int unsigned max_burst, int unsigned n_feature);
    return $clog2(max_burst * n_feature / 2);
  endfunction

  // Two 32-bit features per 64-bit memory word.
  function automatic int unsigned words_per_sample_log2(int unsigned n_feature);
    return $clog2(n_feature / 2);
  endfunction

endpackage

// File: rtl/trees_burst_driver_if.sv
// Host stream, status and accelerator port bundle for the burst driver.
interface trees_burst_driver_if #(
  parameter int unsigned BLW = 14,
  parameter int unsigned FAW = 17
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [BLW-1:0] cfg_burst_len;
  logic           feat_valid;
  logic           feat_ready;
  logic [63:0]    feat_data;
  logic           pred_valid;
  logic           pred_ready;
  logic [63:0]    pred_data;
  logic           pred_last;
  logic           busy;
  logic           done;
  logic           err;
  logic           acc_load_features;
  logic [FAW-1:0] acc_feature_addr;
  logic [63:0]    acc_features2;
  logic [BLW-1:0] acc_burst_len;
  logic           acc_start;
  logic           acc_done;
  logic [BLW-1:0] acc_prediction_addr;
  logic [63:0]    acc_prediction;

  modport master (
    input  cfg_valid, cfg_burst_len, feat_valid, feat_data, pred_ready, acc_done, acc_prediction,
    output cfg_ready, feat_ready, pred_valid, pred_data, pred_last, busy, done, err,
           acc_load_features, acc_feature_addr, acc_features2, acc_burst_len, acc_start,
           acc_prediction_addr
  );

  modport slave (
    output cfg_valid, cfg_burst_len, feat_valid, feat_data, pred_ready, acc_done, acc_prediction,
    input  cfg_ready, feat_ready, pred_valid, pred_data, pred_last, busy, done, err,
           acc_load_features, acc_feature_addr, acc_features2, acc_burst_len, acc_start,
           acc_prediction_addr
  );
endinterface

// File: rtl/trees_burst_driver.sv
// Burst driver: loads features into the accelerator, starts it, waits for done and streams
// the packed 8-bit predictions back out as 64-bit words.
module trees_burst_driver
  import trees_burst_driver_pkg::*;
#(
  parameter int unsigned N_FEATURE = 32,
  parameter int unsigned MAX_BURST = 5000
) (
  input logic                 clk,
  input logic                 rst_n,
  trees_burst_driver_if.master bus
);

  localparam int unsigned BLW      = burst_len_width(MAX_BURST);
  localparam int unsigned FAW      = feat_addr_width(MAX_BURST, N_FEATURE);
  localparam int unsigned WPS_LOG2 = words_per_sample_log2(N_FEATURE);

  typedef logic [BLW-1:0] blen_t;
  typedef logic [FAW:0]   wcnt_t;

  localparam blen_t MaxBurstLen = blen_t'(MAX_BURST);

  drv_state_e     state_q, state_d;
  blen_t          len_q, len_d;
  logic           err_q, err_d;
  wcnt_t          wcnt_q, wcnt_d;
  blen_t          pidx_q, pidx_d;
  logic           load_q;
  logic [FAW-1:0] faddr_q;
  logic [63:0]    fdata_q;
  logic           start_q;

  wcnt_t       words_total;
  blen_t       pred_words;
  logic        last_word;
  logic [2:0]  rem;
  logic        feat_fire;
  logic [63:0] masked_pred;

  assign words_total = wcnt_t'(len_q) << WPS_LOG2;
  assign pred_words  = (len_q + blen_t'(7)) >> 3;
  assign last_word   = (pidx_q == pred_words - blen_t'(1));
  assign rem         = len_q[2:0];
  assign feat_fire   = (state_q == StLoad) && bus.feat_valid;

  // Bytes past the burst end on a partial final word come out as zero.
  always_comb begin
    masked_pred = bus.acc_prediction;
    for (int k = 0; k < 8; k++) begin
      if (last_word && (rem != 3'd0) && (3'(k) >= rem)) begin
        masked_pred[8*k +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    err_d          = err_q;
    wcnt_d         = wcnt_q;
    pidx_d         = pidx_q;
    bus.cfg_ready  = 1'b0;
    bus.feat_ready = 1'b0;
    bus.pred_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          len_d  = bus.cfg_burst_len;
          wcnt_d = '0;
          pidx_d = '0;
          if (bus.cfg_burst_len == '0) begin
            err_d   = 1'b0;
            state_d = StFin;
          end else if (bus.cfg_burst_len > MaxBurstLen) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            err_d   = 1'b0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        bus.feat_ready = 1'b1;
        if (bus.feat_valid) begin
          wcnt_d = wcnt_q + wcnt_t'(1);
          if (wcnt_q == words_total - wcnt_t'(1)) begin
            state_d = StStart;
          end
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        if (bus.acc_done) begin
          pidx_d  = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        bus.pred_valid = 1'b1;
        if (bus.pred_ready) begin
          pidx_d = pidx_q + blen_t'(1);
          if (last_word) begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      pidx_q  <= '0;
      load_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      pidx_q  <= pidx_d;
      load_q  <= feat_fire;
      if (feat_fire) begin
        faddr_q <= wcnt_q[FAW-1:0];
        fdata_q <= bus.feat_data;
      end
      // Delayed one cycle so start follows the registered final write.
      start_q <= (state_q == StStart);
    end
  end

  assign bus.pred_data           = (state_q == StDrain) ? masked_pred : 64'h0;
  assign bus.pred_last           = (state_q == StDrain) && last_word;
  assign bus.busy                = (state_q != StIdle);
  assign bus.done                = (state_q == StFin);
  assign bus.err                 = err_q;
  assign bus.acc_load_features   = load_q;
  assign bus.acc_feature_addr    = faddr_q;
  assign bus.acc_features2       = fdata_q;
  assign bus.acc_burst_len       = len_q;
  assign bus.acc_start           = start_q;
  assign bus.acc_prediction_addr = pidx_q;

endmodule
